// File: rtl/cpu0_pkg.sv
// Shared cpu0 definitions: bus size encodings, the I/O port address map,
// status/control register bit positions and the unpacker state encoding.
package cpu0_pkg;

    // CPU access sizes carried on m_size
    typedef enum logic [1:0] {
        BYTE  = 2'b00,
        INT16 = 2'b01,
        INT24 = 2'b10,
        INT32 = 2'b11
    } size_e;

    // Character-output data port; the status/control register sits one word above
    localparam logic [31:0] CPU0_IOADDR = 32'h0008_0000;

    // Status register bit positions (count occupies the low bits)
    localparam int STS_FULL  = 8;
    localparam int STS_BUSY  = 9;
    localparam int STS_OVF   = 10;
    localparam int STS_IRQEN = 11;

    // Control register bit positions
    localparam int CTL_CLR_OVF = 0;
    localparam int CTL_IRQEN   = 1;

    // Store-word unpacker states
    typedef enum logic {
        ST_IDLE,
        ST_UNPACK
    } unpack_state_e;

    // Number of bytes a store emits: a byte store always emits its byte,
    // wider stores emit bytes low-first up to (not including) the first zero.
    function automatic logic [2:0] emit_count(input logic [31:0] word, input size_e size);
        logic [2:0] limit;
        logic [2:0] n;
        logic       stop;
        limit = {1'b0, size} + 3'd1;
        n     = 3'd0;
        stop  = 1'b0;
        if (size == BYTE) begin
            n = 3'd1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!stop && (3'(i) < limit) && (word[8*i +: 8] != 8'h00)) begin
                    n = n + 3'd1;
                end else begin
                    stop = 1'b1;
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/cpu0_io_port_if.sv
// Bus request and byte-stream signals of the cpu0 character-output port.
// The master side is the CPU bus plus the console sink; the slave is the port.
interface cpu0_io_port_if;

    logic        en;
    logic        rw;
    logic [1:0]  m_size;
    logic [31:0] abus;
    logic [31:0] dbus_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output en, rw, m_size, abus, dbus_in, tx_ready,
        input  tx_data, tx_valid
    );

    modport slave (
        input  en, rw, m_size, abus, dbus_in, tx_ready,
        output tx_data, tx_valid
    );

endinterface

// File: rtl/cpu0_byte_fifo.sv
// Synchronous byte FIFO with occupancy count. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module cpu0_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Byte storage written at the tail
    // NOTE: storage has no reset; occupancy is tracked by count, so stale bytes are never visible.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks net pushes minus pops
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu0_io_port.sv
// cpu0 memory-mapped character-output port: decodes CPU stores, unpacks the
// stored word into bytes, queues them and streams them to a console sink.
module cpu0_io_port
    import cpu0_pkg::*;
#(
    parameter logic [31:0] IOADDR = CPU0_IOADDR,
    parameter int          DEPTH  = 16,
    parameter int          AW     = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    cpu0_io_port_if.slave        bus,
    // Read data stays a plain tri-state port so it can share the CPU data bus
    output logic [31:0]          dbus_out,
    output logic                 irq
);

    // Bus decode
    logic          en_q;
    logic          accept;
    logic          data_sel;
    logic          ctl_sel;
    logic          wr_data;
    logic          wr_ctl;
    logic          rd_sts;
    size_e         req_size;
    logic [2:0]    req_len;
    logic          start;
    logic          drop;

    // Unpacker
    unpack_state_e state;
    unpack_state_e state_next;
    logic [31:0]   word_q;
    logic [2:0]    len_q;
    logic [1:0]    idx_q;
    logic          push;
    logic          last;
    logic          busy;
    logic [7:0]    push_byte;

    // Status / control
    logic          overflow;
    logic          irq_en;
    logic [31:0]   status_word;

    // FIFO
    logic [7:0]    fifo_rd_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;
    logic          pop;

    // An access is taken on the first edge that sees en, so a held en counts once
    assign accept   = bus.en && !en_q;
    assign data_sel = (bus.abus == IOADDR);
    assign ctl_sel  = (bus.abus == IOADDR + 32'd4);
    assign wr_data  = accept && !bus.rw && data_sel;
    assign wr_ctl   = accept && !bus.rw && ctl_sel;
    assign rd_sts   = bus.en && bus.rw && ctl_sel;

    assign req_size = size_e'(bus.m_size);
    assign req_len  = emit_count(bus.dbus_in, req_size);
    assign start    = wr_data && (state == ST_IDLE) && (req_len != 3'd0);
    assign drop     = wr_data && (state == ST_UNPACK);

    assign pop          = bus.tx_valid && bus.tx_ready;
    assign bus.tx_valid = !fifo_empty;
    assign bus.tx_data  = fifo_empty ? 8'h00 : fifo_rd_data;

    cpu0_byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_byte),
        .pop       (pop),
        .rd_data   (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Unpacker state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Unpacker next-state: start on a store with bytes to emit, finish after the last push
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_UNPACK;
            ST_UNPACK: if (push && last) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Unpacker outputs: one byte per cycle whenever the FIFO has (or is freeing) a slot
    always_comb begin
        busy      = (state == ST_UNPACK);
        push      = busy && (!fifo_full || pop);
        last      = ({1'b0, idx_q} == (len_q - 3'd1));
        push_byte = word_q[{idx_q, 3'b000} +: 8];
    end

    // Unpacker datapath: latch the stored word and its emit length, then step the byte index
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
            len_q  <= '0;
            idx_q  <= '0;
        end else if (start) begin
            word_q <= bus.dbus_in;
            len_q  <= req_len;
            idx_q  <= '0;
        end else if (push) begin
            idx_q  <= idx_q + 2'd1;
        end
    end

    // Edge-detect register, sticky overflow, irq enable and the registered interrupt
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            en_q     <= 1'b0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            en_q <= bus.en;
            // A store dropped while busy wins over a simultaneous clear
            if (drop) begin
                overflow <= 1'b1;
            end else if (wr_ctl && bus.dbus_in[CTL_CLR_OVF]) begin
                overflow <= 1'b0;
            end
            if (wr_ctl) begin
                irq_en <= bus.dbus_in[CTL_IRQEN];
            end
            irq <= (fifo_count == '0) && irq_en;
        end
    end

    // Status register image
    always_comb begin
        status_word            = '0;
        status_word[AW:0]      = fifo_count;
        status_word[STS_FULL]  = fifo_full;
        status_word[STS_BUSY]  = busy;
        status_word[STS_OVF]   = overflow;
        status_word[STS_IRQEN] = irq_en;
    end

    // Only a status read drives the shared data bus
    assign dbus_out = rd_sts ? status_word : {32{1'bz}};

endmodule

// File: tb/tb_cpu0_io_port.sv
// Directed self-checking bench for cpu0_io_port.
module tb_cpu0_io_port;
    import cpu0_pkg::*;

    localparam logic [31:0] IOADDR  = CPU0_IOADDR;
    localparam logic [31:0] CTLADDR = CPU0_IOADDR + 32'd4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    wire  [31:0] dbus_out;
    wire         irq;
    int          errors = 0;
    int          checks = 0;

    cpu0_io_port_if bus ();

    cpu0_io_port #(
        .IOADDR (IOADDR),
        .DEPTH  (16),
        .AW     (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .dbus_out (dbus_out),
        .irq      (irq)
    );

    always #5 clock = ~clock;

    // Undriven bus: z in a 4-state simulator, 0 in a 2-state one
    function automatic bit is_hiz(input logic [31:0] v);
        return (v === {32{1'bz}}) || (v === 32'h0);
    endfunction

    // One bus store; returns at the falling edge right after the accept edge
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        @(negedge clock);
        bus.en      = 1'b1;
        bus.rw      = 1'b0;
        bus.abus    = addr;
        bus.dbus_in = data;
        bus.m_size  = size;
        @(negedge clock);
        bus.en      = 1'b0;
    endtask

    // Combinational read inside the low clock phase; no clock edge sees en
    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus.rw   = 1'b1;
        bus.abus = addr;
        bus.en   = 1'b1;
        #1;
        data     = dbus_out;
        bus.en   = 1'b0;
        bus.rw   = 1'b0;
    endtask

    // Poll the busy bit for a bounded number of cycles
    task automatic wait_idle(output bit timed_out);
        logic [31:0] s;
        timed_out = 1'b1;
        for (int c = 0; c < 12; c++) begin
            bus_read(CTLADDR, s);
            if (s[STS_BUSY] === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        logic [31:0] s;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.tx_valid !== 1'b0) begin
            errors++; $display("FAIL reset_hold_tx_valid: got %b want 0", bus.tx_valid);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin
            errors++; $display("FAIL reset_tx: valid %b data %h want 0/00", bus.tx_valid, bus.tx_data);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL reset_irq: got %b want 0", irq);
        end
        checks++;
        if (!is_hiz(dbus_out)) begin
            errors++; $display("FAIL reset_dbus_idle: got %h want hi-z", dbus_out);
        end
        bus_read(CTLADDR, s);
        checks++;
        if (s !== 32'h0) begin
            errors++; $display("FAIL reset_status: got %h want 00000000", s);
        end
    endtask

    task automatic test_word_stream();
        logic [7:0]  exp_bytes [3] = '{8'h61, 8'h62, 8'h63};
        logic [31:0] s;
        bit          found;
        bus.tx_ready = 1'b1;
        bus_write(IOADDR, 32'h0063_6261, 2'b11);
        checks++;
        if (bus.tx_valid !== 1'b0) begin
            errors++; $display("FAIL word_early_valid: got %b on accept edge want 0", bus.tx_valid);
        end
        found = 1'b0;
        for (int k = 0; k < 2 && !found; k++) begin
            @(negedge clock);
            if (bus.tx_valid === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL word_latency: no tx_valid within 2 cycles of accept");
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp_bytes[i]) begin
                errors++;
                $display("FAIL word_byte_%0d: valid %b data %h want 1/%h", i, bus.tx_valid, bus.tx_data, exp_bytes[i]);
            end
            @(negedge clock);
        end
        checks++;
        if (bus.tx_valid !== 1'b0) begin
            errors++; $display("FAIL word_zero_emitted: tx_valid %b data %h want 0", bus.tx_valid, bus.tx_data);
        end
        bus_read(CTLADDR, s);
        checks++;
        if (s !== 32'h0) begin
            errors++; $display("FAIL word_status_after: got %h want 00000000", s);
        end
    endtask

    task automatic test_byte_and_zero();
        logic [31:0] s;
        bit          found;
        int          seen;
        bus.tx_ready = 1'b1;
        bus_write(IOADDR, 32'hFFFF_FF00, 2'b00);
        found = 1'b0;
        for (int k = 0; k < 3 && !found; k++) begin
            if (bus.tx_valid === 1'b1) found = 1'b1;
            else @(negedge clock);
        end
        checks++;
        if (!found || bus.tx_data !== 8'h00) begin
            errors++; $display("FAIL byte_store: found %b data %h want 1/00", found, bus.tx_data);
        end
        @(negedge clock);
        checks++;
        if (bus.tx_valid !== 1'b0) begin
            errors++; $display("FAIL byte_store_single: tx_valid %b data %h want 0", bus.tx_valid, bus.tx_data);
        end
        bus_write(IOADDR, 32'h0000_4100, 2'b01);
        bus_read(CTLADDR, s);
        checks++;
        if (s !== 32'h0) begin
            errors++; $display("FAIL half_zero_status: got %h want 00000000", s);
        end
        seen = 0;
        repeat (4) begin
            @(negedge clock);
            if (bus.tx_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL half_zero_emitted: %0d valid cycles want 0", seen);
        end
    endtask

    task automatic test_held_en();
        logic [31:0] s;
        bus.tx_ready = 1'b0;
        @(negedge clock);
        bus.en      = 1'b1;
        bus.rw      = 1'b0;
        bus.abus    = IOADDR;
        bus.dbus_in = 32'h0000_0041;
        bus.m_size  = 2'b11;
        repeat (3) @(negedge clock);
        bus.en      = 1'b0;
        @(negedge clock);
        bus_read(CTLADDR, s);
        checks++;
        if (s !== 32'h0000_0001) begin
            errors++; $display("FAIL held_en_once: status %h want 00000001", s);
        end
        bus.tx_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.tx_valid !== 1'b0) begin
            errors++; $display("FAIL held_en_drain: tx_valid %b want 0", bus.tx_valid);
        end
    endtask

    task automatic test_fill_overflow();
        logic [31:0] s;
        bit          to;
        int          got;
        logic [7:0]  exp;
        bus.tx_ready = 1'b0;
        for (int w = 0; w < 4; w++) begin
            bus_write(IOADDR, 32'h4443_4241, 2'b11);
            wait_idle(to);
            checks++;
            if (to) begin
                errors++; $display("FAIL fill_idle_%0d: still busy after 12 cycles want idle", w);
            end
        end
        bus_read(CTLADDR, s);
        checks++;
        if (s !== 32'h0000_0110) begin
            errors++; $display("FAIL fill_full_status: got %h want 00000110", s);
        end
        bus_read(IOADDR, s);
        checks++;
        if (!is_hiz(s)) begin
            errors++; $display("FAIL data_addr_read: got %h want hi-z", s);
        end
        bus_write(IOADDR, 32'h4443_4241, 2'b11);
        repeat (2) @(negedge clock);
        bus_read(CTLADDR, s);
        checks++;
        if (s !== 32'h0000_0310) begin
            errors++; $display("FAIL stall_status: got %h want 00000310", s);
        end
        bus_write(IOADDR, 32'h4847_4645, 2'b11);
        bus_read(CTLADDR, s);
        checks++;
        if (s !== 32'h0000_0710) begin
            errors++; $display("FAIL overflow_status: got %h want 00000710", s);
        end
        bus_write(CTLADDR, 32'h0000_0001, 2'b11);
        bus_read(CTLADDR, s);
        checks++;
        if (s !== 32'h0000_0310) begin
            errors++; $display("FAIL clear_ovf_status: got %h want 00000310", s);
        end
        bus.tx_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 60 && got < 20; c++) begin
            if (bus.tx_valid === 1'b1) begin
                exp = 8'h41 + 8'(got % 4);
                checks++;
                if (bus.tx_data !== exp) begin
                    errors++; $display("FAIL drain_byte_%0d: got %h want %h", got, bus.tx_data, exp);
                end
                got++;
            end
            @(negedge clock);
        end
        checks++;
        if (got != 20 || bus.tx_valid !== 1'b0) begin
            errors++; $display("FAIL drain_total: %0d bytes, tail valid %b want 20/0", got, bus.tx_valid);
        end
        bus_read(CTLADDR, s);
        checks++;
        if (s !== 32'h0) begin
            errors++; $display("FAIL drain_status: got %h want 00000000", s);
        end
    endtask

    task automatic test_irq();
        bus.tx_ready = 1'b0;
        bus_write(CTLADDR, 32'h0000_0002, 2'b11);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_lag: got %b on enable edge want 0", irq);
        end
        @(negedge clock);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_enable: got %b want 1", irq);
        end
        bus_write(IOADDR, 32'h0000_0041, 2'b11);
        repeat (2) @(negedge clock);
        checks++;
        if (irq !== 1'b0 || bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h41) begin
            errors++;
            $display("FAIL irq_queued: irq %b valid %b data %h want 0/1/41", irq, bus.tx_valid, bus.tx_data);
        end
        bus.tx_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.tx_valid !== 1'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL irq_pop_edge: valid %b irq %b want 0/0", bus.tx_valid, irq);
        end
        @(negedge clock);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_after_pop: got %b want 1", irq);
        end
        bus_write(CTLADDR, 32'h0000_0000, 2'b11);
        @(negedge clock);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_disable: got %b want 0", irq);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] s;
        int          seen;
        bus.tx_ready = 1'b0;
        bus_write(IOADDR, 32'h4443_4241, 2'b11);
        repeat (2) @(negedge clock);
        bus_read(CTLADDR, s);
        checks++;
        if (s !== 32'h0000_0202) begin
            errors++; $display("FAIL mid_status: got %h want 00000202", s);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin
            errors++; $display("FAIL mid_async_reset: valid %b data %h want 0/00", bus.tx_valid, bus.tx_data);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        bus_read(CTLADDR, s);
        checks++;
        if (s !== 32'h0) begin
            errors++; $display("FAIL mid_post_status: got %h want 00000000", s);
        end
        bus.tx_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (bus.tx_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL mid_residual: %0d valid cycles want 0", seen);
        end
    endtask

    initial begin
        bus.en       = 1'b0;
        bus.rw       = 1'b0;
        bus.m_size   = 2'b00;
        bus.abus     = '0;
        bus.dbus_in  = '0;
        bus.tx_ready = 1'b0;
        test_reset();
        test_word_stream();
        test_byte_and_zero();
        test_held_en();
        test_fill_overflow();
        test_irq();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu0_io_port.md
Name: cpu0_io_port

Overview:
- Memory-mapped character-output port sitting on the cpu0 memory bus, alongside memory0, directly downstream of the CPU's store path.
- Decodes stores to IOADDR and unpacks the stored word into bytes using the CPU's output rules.
- Buffers the bytes in a FIFO and streams them to a console/UART transmitter over a valid/ready interface.
- Exposes a status/control register at IOADDR+4 and a FIFO-empty interrupt.

Parameters:
- IOADDR, 'h80000, data port address (byte write target).
- DEPTH, 16, FIFO depth in bytes (power of 2, >= 4).
- AW, 4, log2(DEPTH).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  bus enable from CPU.
- rw  in  1  1 = read, 0 = write.
- m_size  in  2  access size: 00 byte, 01 16-bit, 10 24-bit, 11 32-bit.
- abus  in  32  bus address (CPU mar).
- dbus_in  in  32  write data (CPU mdr).
- dbus_out  out  32  status read data; Z when not selected.
- tx_data  out  8  head byte of FIFO.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  sink accepts byte.
- irq  out  1  level interrupt: FIFO empty AND irq_en.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers and count cleared; unpacker idle.
  - overflow=0, irq_en=0, en_q=0.
  - Outputs: tx_valid=0, tx_data=0, irq=0, dbus_out=Z (no read selected).
- Access detection:
  - Accept event = en && !en_q on a rising edge (en_q is en registered).
  - An en pulse held for several cycles is accepted once.
- Data write (rw=0, abus==IOADDR):
  - Latch dbus_in and a byte count from m_size: 1/2/3/4.
  - Unpacker emits bytes low byte first (dbus_in[7:0], then [15:8], ...).
  - BYTE size: byte 0 is always pushed, even 8'h00.
  - Sizes 01/10/11: stop at the first 8'h00 byte; the zero byte is not pushed. Byte 0 == 0 pushes nothing and the unpacker stays idle.
- Unpacker FSM, states IDLE and UNPACK:
  - IDLE -> UNPACK on an accepted data write with at least one byte to emit.
  - In UNPACK, push one byte per cycle when FIFO can accept.
  - Stall while FIFO is full and no pop occurs that cycle.
  - UNPACK -> IDLE after the last byte or on a zero byte.
  - Latency: first byte appears on tx_valid/tx_data 2 cycles after the accept edge; a 4-byte word is fully pushed in 4 cycles with no stall.
- Write while UNPACK busy: the new word is dropped and overflow is set (sticky).
- Control write (rw=0, abus==IOADDR+4):
  - bit0=1 clears overflow.
  - bit1 loads irq_en.
  - A set and a clear of overflow in the same cycle resolve to set.
- Status read (rw=1, en=1, abus==IOADDR+4), combinational same-cycle response:
  - dbus_out[AW:0] = count.
  - bit8 = full, bit9 = busy (UNPACK), bit10 = overflow, bit11 = irq_en.
  - All other bits 0.
  - Any other read: dbus_out=Z. Reads of IOADDR also return Z.
- FIFO:
  - Push allowed if !full, or if a pop occurs in the same cycle (simultaneous push+pop when full keeps count=DEPTH).
  - Pop on tx_valid && tx_ready.
  - Pointers wrap modulo DEPTH; count is AW+1 bits, range 0..DEPTH.
  - tx_data is valid only while tx_valid=1 and holds stable until popped.
- irq = (count==0) && irq_en, registered, one-cycle lag after the final pop.
- Addresses outside {IOADDR, IOADDR+4} are ignored. There is no overlap with memory0, whose decode ends at MEMSIZE-4.
- Reset mid-operation: all state clears immediately; the in-flight word is lost; tx_valid falls asynchronously.

Decomposition:
- Shared package cpu0_pkg:
  - Size encodings BYTE/INT16/INT24/INT32.
  - IOADDR constant.
  - Status bit positions (STS_FULL=8, STS_BUSY=9, STS_OVF=10, STS_IRQEN=11).
  - Control bit positions (CTL_CLR_OVF=0, CTL_IRQEN=1).
  - Unpacker state enum.
- Sub-module cpu0_byte_fifo: parameterised DEPTH/AW, 8-bit sync FIFO with push/pop/full/empty/count. The top level holds decode, unpacker, status and irq.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release -> tx_valid=0, irq=0, dbus_out=Z; status read at IOADDR+4 returns 32'h0.
- 32-bit store of 32'h00636261 to IOADDR with tx_ready=1 -> bytes 61,62,63 appear on consecutive cycles, then tx_valid=0; the zero byte is never emitted.
- Byte store of 32'hFFFFFF00 at m_size=00 -> exactly one byte 8'h00 emitted. A 16-bit store of 32'h00004100 -> nothing emitted, busy stays 0.
- Fill with tx_ready=0: four 32-bit stores of 32'h44434241 -> count=16 and full=1. A fifth store stalls the unpacker (busy=1), and a sixth store sets overflow; status reads 32'h710. Control write 32'h1 gives 32'h310. Raising tx_ready drains "ABCD" x4, then the four bytes of the stalled fifth word.
- irq: control write 32'h2 with FIFO empty -> irq=1 next cycle. Store 32'h00000041 -> irq=0 while the byte is queued, returning to 1 one cycle after the pop.
- Reset mid-unpack: tx_ready=0, store 32'h44434241, assert reset after 2 bytes pushed -> tx_valid=0 immediately. After release, count=0 and no residual bytes are emitted.
